axi_read_responder: RTL
=======================

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning AXI address width.
REQ-002 The block SHALL have parameter DW, default 64, meaning AXI read data width (fixed to 64).
REQ-003 The block SHALL have parameter MEM_AW, default 10, meaning backing-memory word-address width.
REQ-004 The block SHALL have port axi_aclk, input, 1, the single clock.
REQ-005 The block SHALL have port axi_aresetn, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port axi_araddr, input, AW, read burst start address.
REQ-007 The block SHALL have ports axi_arlen (input, 8), axi_arsize (input, 3) and axi_arburst (input, 2), the burst length-1, size and type.
REQ-008 The block SHALL have ports axi_arvalid (input, 1) and axi_arready (output, 1), the AR handshake.
REQ-009 The block SHALL have ports axi_rdata (output, 64), axi_rresp (output, 2) and axi_rlast (output, 1), the read beat data, status and last flag.
REQ-010 The block SHALL have ports axi_rvalid (output, 1) and axi_rready (input, 1), the R handshake.
REQ-011 The block SHALL have ports mem_rd_en (output, 1), mem_rd_addr (output, MEM_AW) and mem_rd_data (input, 64), a synchronous memory read port with 1-cycle latency.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, WAITD and SEND; it accepts one burst at a time, with no outstanding reads.
REQ-013 In IDLE, axi_arready SHALL be 1; AR fire (arvalid&&arready) SHALL latch addr/len/size/burst, clear the beat counter, drop arready and go to FETCH.
REQ-014 In FETCH, the block SHALL pulse mem_rd_en for 1 cycle with mem_rd_addr=addr[MEM_AW+2:3] and go to WAITD; in WAITD it SHALL capture mem_rd_data into axi_rdata, set rvalid=1 and go to SEND.
REQ-015 First-beat latency SHALL be rvalid high 3 cycles after the AR-fire edge; steady state SHALL be one beat per 3 cycles.
REQ-016 In SEND, rdata/rresp/rlast SHALL hold stable while rvalid&&!rready; on R fire, if rlast the block SHALL go to IDLE (arready=1 next cycle), otherwise it SHALL advance the address and beat counter and go to FETCH.
REQ-017 axi_rlast SHALL be 1 exactly on beat index == latched len.
REQ-018 Address generation SHALL use beat bytes = 1<<size: FIXED (00) keeps the address constant; INCR (01) computes next = (addr & ~(bytes-1)) + bytes, wrapping modulo 2^AW.
REQ-019 WRAP (10) SHALL use container = (len+1)*bytes, next = (addr & ~(container-1)) | ((addr+bytes) & (container-1)).
REQ-020 Burst type 11, size>3, or WRAP with len not in {1,3,7,15} SHALL return all len+1 beats with rresp=SLVERR (2'b10), rdata=0 and no mem_rd_en.
REQ-021 All other beats SHALL return rresp=OKAY (2'b00).
REQ-022 An arvalid arriving in any state other than IDLE SHALL be ignored until IDLE.

Reset
REQ-023 On axi_aresetn low the block SHALL immediately force: state IDLE, axi_arready 0, axi_rvalid 0, axi_rlast 0, axi_rresp 00, axi_rdata 0 and mem_rd_en 0; it SHALL set arready=1 on the first clock after release.
REQ-024 Reset mid-burst SHALL abandon the burst with no further beats.

Configuration
REQ-025 With AXI_RD_RANGE_CHECK_EN defined, beats whose byte address is >= 2^(MEM_AW+3) SHALL return SLVERR, rdata 0 and no mem_rd_en; without the macro, the address SHALL be truncated to MEM_AW word bits and always return OKAY (unless REQ-020 applies).

Structure
REQ-026 Package axi_pkg SHALL hold the burst-type localparams (FIXED/INCR/WRAP), rresp codes (OKAY/SLVERR) and the FSM state enum.
REQ-027 Sub-module axi_burst_addr_gen (combinational: addr, size, len, burst -> next_addr, illegal flag) SHALL be instantiated once.

Verification
REQ-028 The bench SHALL check: araddr=0x10, len=0, size=3, INCR -> one beat, mem addr 2, rlast=1, OKAY, rvalid 3 cycles after AR fire.
REQ-029 The bench SHALL check: araddr=0x38, len=3, size=3, WRAP -> word addresses 7,4,5,6; rlast on the 4th beat.
REQ-030 The bench SHALL check: araddr=0x08, len=3, size=3, FIXED with rready low 5 cycles on beat 1 -> rdata stable, all beats at word 1.
REQ-031 The bench SHALL check: arburst=11, len=2 -> three SLVERR beats, mem_rd_en never asserted.
REQ-032 The bench SHALL check: reset asserted during beat 2 of len=7 -> rvalid 0 immediately, arready 1 one cycle after release, and a new burst served correctly.
REQ-033 With AXI_RD_RANGE_CHECK_EN and MEM_AW=10, the bench SHALL check: araddr=0x2000 -> SLVERR; without the macro -> OKAY from word 0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-side encodings and the responder FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAITD = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus a flag for
// burst shapes the responder refuses (reserved type, oversize, bad WRAP length).
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_addr,
    input  logic [2:0]    i_size,
    input  logic [7:0]    i_len,
    input  logic [1:0]    i_burst,
    output logic [AW-1:0] o_next_addr,
    output logic          o_illegal
);

    logic [AW-1:0] w_bytes;
    logic [AW-1:0] w_container;
    logic [AW-1:0] w_incr;
    logic          w_wrap_len_ok;

    always_comb begin
        w_bytes       = AW'(1) << i_size;
        w_container   = (AW'(i_len) + AW'(1)) * w_bytes;
        w_incr        = (i_addr & ~(w_bytes - AW'(1))) + w_bytes;
        w_wrap_len_ok = (i_len == 8'd1) || (i_len == 8'd3) ||
                        (i_len == 8'd7) || (i_len == 8'd15);

        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incr;
            // Container is a power of two whenever the WRAP length is legal.
            BURST_WRAP:  o_next_addr = (i_addr & ~(w_container - AW'(1))) |
                                       ((i_addr + w_bytes) & (w_container - AW'(1)));
            default:     o_next_addr = i_addr;
        endcase

        o_illegal = (i_burst == 2'b11) || (i_size > 3'd3) ||
                    ((i_burst == BURST_WRAP) && !w_wrap_len_ok);
    end

endmodule

// File: rtl/axi_read_responder.sv
// Single-outstanding AXI read slave over a 1-cycle-latency synchronous memory.
// Define AXI_RD_RANGE_CHECK_EN to answer out-of-range byte addresses with SLVERR.
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 64,
    parameter int MEM_AW = 10
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic [AW-1:0]     axi_araddr,
    input  logic [7:0]        axi_arlen,
    input  logic [2:0]        axi_arsize,
    input  logic [1:0]        axi_arburst,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [DW-1:0]     axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [DW-1:0]     mem_rd_data,
    output logic [1:0]        o_dbg_state
);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_len;
    logic [2:0]    r_size;
    logic [1:0]    r_burst;
    logic [7:0]    r_beat;
    logic          r_arready;
    logic          r_rvalid;
    logic          r_rlast;
    logic [1:0]    r_rresp;
    logic [DW-1:0] r_rdata;

    logic [AW-1:0] w_next_addr;
    logic          w_illegal;
    logic          w_range_err;
    logic          w_beat_err;

    axi_burst_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_illegal   (w_illegal)
    );

`ifdef AXI_RD_RANGE_CHECK_EN
    assign w_range_err = |(r_addr >> (MEM_AW + 3));
`else
    assign w_range_err = 1'b0;
`endif

    // Error beats still walk FETCH/WAITD so every beat keeps the same cadence.
    assign w_beat_err  = w_illegal || w_range_err;
    assign mem_rd_en   = (r_state == ST_FETCH) && !w_beat_err;
    assign mem_rd_addr = r_addr[MEM_AW+2:3];

    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rlast   = r_rlast;
    assign axi_rresp   = r_rresp;
    assign axi_rdata   = r_rdata;
    assign o_dbg_state = r_state;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_arready <= 1'b1;
                    if (axi_arvalid && r_arready) begin
                        r_addr    <= axi_araddr;
                        r_len     <= axi_arlen;
                        r_size    <= axi_arsize;
                        r_burst   <= axi_arburst;
                        r_beat    <= '0;
                        r_arready <= 1'b0;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAITD;
                end
                ST_WAITD: begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_beat_err ? '0 : mem_rd_data;
                    r_rresp  <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
                    r_rlast  <= (r_beat == r_len);
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_arready <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_beat  <= r_beat + 8'd1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
